// File: rtl/parity_gen_check.sv
// parity_gen_check
//   Pipelined parity generator/checker for DATA_W-bit words. A word accepted
//   over the in_valid/in_ready handshake is registered into a one-deep output
//   stage. The output stage holds the word, its generated parity bit and an
//   optional check result. A saturating error counter and a sticky error flag
//   track accepted mismatches.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   odd_mode, chk_en    per-word mode controls, sampled on accept
//   in_valid/in_ready   input handshake; in_data, in_parity = word and received parity
//   out_valid/out_ready output handshake; out_data, out_parity, out_err
//   err_cnt, sticky_err accepted-mismatch counter (saturating) and sticky flag
//   clr_err             synchronous clear of err_cnt/sticky_err
module parity_gen_check #(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              odd_mode,
  input  logic              chk_en,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_parity,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_parity,
  output logic              out_err,
  output logic [CNT_W-1:0]  err_cnt,
  output logic              sticky_err,
  input  logic              clr_err
);

  typedef struct packed {
    logic [DATA_W-1:0] data;
    logic              parity;
    logic              err;
  } word_t;

  word_t             word_d, word_q;
  logic              out_valid_d, out_valid_q;
  logic [CNT_W-1:0]  err_cnt_d, err_cnt_q;
  logic              sticky_d, sticky_q;

  logic gen, mismatch, accept, xfer;

  // Odd mode flips the even-parity bit so data+parity has an odd ones count.
  assign gen      = (^in_data) ^ odd_mode;
  assign mismatch = chk_en & (in_parity != gen);

  // Ready is combinational off the downstream ready so a draining stage can
  // refill in the same edge (no bubble). Held low during reset.
  assign in_ready = rst_n & (~out_valid_q | out_ready);
  assign accept   = in_valid & in_ready;
  assign xfer     = out_valid_q & out_ready;

  always_comb begin
    word_d      = word_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      word_d      = '{data: in_data, parity: gen, err: mismatch};
      out_valid_d = 1'b1;
    end else if (xfer) begin
      // Payload holds its last value after it drains.
      out_valid_d = 1'b0;
    end
  end

  always_comb begin
    err_cnt_d = err_cnt_q;
    sticky_d  = sticky_q;
    // Clear wins over a same-cycle mismatch; that error is dropped from the
    // count and flag but still shows up on out_err.
    if (clr_err) begin
      err_cnt_d = '0;
      sticky_d  = 1'b0;
    end else if (accept && mismatch) begin
      sticky_d = 1'b1;
      if (err_cnt_q != {CNT_W{1'b1}})
        err_cnt_d = err_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_q      <= '0;
      out_valid_q <= 1'b0;
      err_cnt_q   <= '0;
      sticky_q    <= 1'b0;
    end else begin
      word_q      <= word_d;
      out_valid_q <= out_valid_d;
      err_cnt_q   <= err_cnt_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign out_data   = word_q.data;
  assign out_parity = word_q.parity;
  assign out_err    = word_q.err;
  assign err_cnt    = err_cnt_q;
  assign sticky_err = sticky_q;

endmodule

// File: tb/tb_parity_gen_check.sv
module tb_parity_gen_check;
  localparam int DATA_W = 8;
  localparam int CNT_W  = 2;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst_n, odd_mode, chk_en, in_valid, in_parity, out_ready, clr_err;
  logic [DATA_W-1:0] in_data;
  logic in_ready, out_valid, out_parity, out_err, sticky_err;
  logic [DATA_W-1:0] out_data;
  logic [CNT_W-1:0]  err_cnt;

  always #5 clk = ~clk;

  parity_gen_check #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .odd_mode(odd_mode), .chk_en(chk_en),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_parity(in_parity), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_parity(out_parity), .out_err(out_err),
    .err_cnt(err_cnt), .sticky_err(sticky_err), .clr_err(clr_err)
  );

  typedef struct packed {
    logic [DATA_W-1:0] d;
    logic              p;
    logic              e;
  } exp_t;

  exp_t sb[$];
  exp_t last;
  bit   m_valid;
  int   m_cnt;
  bit   m_sticky;
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set(input bit v, input logic [DATA_W-1:0] d, input bit odd,
                     input bit chk, input bit par, input bit ordy, input bit clr);
    in_valid = v; in_data = d; odd_mode = odd; chk_en = chk;
    in_parity = par; out_ready = ordy; clr_err = clr;
  endtask

  // One clock: check handshake/output at negedge, advance the model at the
  // posedge, check counters just after it.
  task automatic cycle();
    exp_t e;
    bit rdy, acc, xf, g, mis;
    @(negedge clk);
    rdy = rst_n && (!m_valid || out_ready);
    check("in_ready", in_ready, rdy);
    check("out_valid", out_valid, m_valid);
    if (m_valid) check("sb_size", sb.size(), 1);
    e = (m_valid && sb.size() > 0) ? sb[0] : last;
    check("out_data", out_data, e.d);
    check("out_parity", out_parity, e.p);
    check("out_err", out_err, e.e);
    @(posedge clk);
    if (!rst_n) begin
      m_valid = 0; sb.delete(); last = '0; m_cnt = 0; m_sticky = 0;
    end else begin
      xf  = m_valid && out_ready;
      acc = in_valid && rdy;
      g   = (^in_data) ^ odd_mode;
      mis = chk_en && (in_parity != g);
      if (xf && sb.size() > 0) last = sb.pop_front();
      if (acc) sb.push_back({in_data, g, mis});
      m_valid = acc || (m_valid && !out_ready);
      if (clr_err) begin
        m_cnt = 0; m_sticky = 0;
      end else if (acc && mis) begin
        m_sticky = 1;
        if (m_cnt < CMAX) m_cnt++;
      end
    end
    #1;
    check("err_cnt", err_cnt, m_cnt);
    check("sticky_err", sticky_err, m_sticky);
  endtask

  function automatic bit bad_par(input logic [DATA_W-1:0] d, input bit odd);
    return ~((^d) ^ odd);
  endfunction

  initial begin
    logic [DATA_W-1:0] stream [3];
    int sat_seq [5];
    stream = '{8'hA5, 8'h01, 8'hFF};
    sat_seq = '{1, 2, 3, 3, 3};
    rst_n = 0;
    set(0, '0, 0, 0, 0, 1, 0);
    m_valid = 0; m_cnt = 0; m_sticky = 0; last = '0;
    repeat (2) @(posedge clk);
    #1;
    // Reset held: in_ready low, outputs zero.
    cycle();
    rst_n = 1;
    cycle();
    cycle();

    // Even mode, no check, back-to-back stream: parities 0,1,0.
    for (int i = 0; i < 3; i++) begin
      set(1, stream[i], 0, 0, 1, 1, 0);
      cycle();
    end
    set(0, '0, 0, 0, 0, 1, 0);
    cycle();
    cycle();

    // Odd mode with check: 03/par1 ok, 07/par1 mismatch.
    set(1, 8'h03, 1, 1, 1, 1, 0);
    cycle();
    set(1, 8'h07, 1, 1, 1, 1, 0);
    cycle();
    check("cnt_after_07", err_cnt, 1);
    check("sticky_after_07", sticky_err, 1);
    set(0, '0, 0, 0, 0, 1, 0);
    cycle();

    // Stall with 3C held; source offers 55 with changing modes meanwhile.
    set(1, 8'h3C, 0, 0, 0, 1, 0);
    cycle();
    for (int i = 0; i < 3; i++) begin
      set(1, 8'h55, i[0], i[1], 1, 0, 0);
      cycle();
    end
    set(1, 8'h55, 1, 1, 0, 1, 0);
    cycle();
    set(0, '0, 0, 0, 0, 1, 0);
    cycle();
    cycle();

    // Saturation on the 2-bit counter, then clear racing a mismatch.
    set(0, '0, 0, 0, 0, 1, 1);
    cycle();
    for (int i = 0; i < 5; i++) begin
      set(1, 8'h10 + i[7:0], i[0], 1, bad_par(8'h10 + i[7:0], i[0]), 1, 0);
      cycle();
      check("sat_seq", err_cnt, sat_seq[i]);
    end
    set(1, 8'h9E, 0, 1, bad_par(8'h9E, 0), 1, 1);
    cycle();
    check("clr_cnt", err_cnt, 0);
    check("clr_sticky", sticky_err, 0);
    set(0, '0, 0, 0, 0, 1, 0);
    cycle();
    cycle();

    // Reset while stalled with err_cnt=2.
    set(1, 8'h21, 0, 1, bad_par(8'h21, 0), 1, 0);
    cycle();
    set(1, 8'h42, 1, 1, bad_par(8'h42, 1), 1, 0);
    cycle();
    set(1, 8'h77, 0, 0, 0, 0, 0);
    cycle();
    check("pre_rst_cnt", err_cnt, 2);
    rst_n = 0;
    cycle();
    check("rst_cnt", err_cnt, 0);
    rst_n = 1;
    set(1, 8'h5A, 1, 1, 1, 1, 0);
    cycle();
    set(0, '0, 0, 0, 0, 1, 0);
    cycle();
    cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/parity_gen_check.md
Name: parity_gen_check

Overview:
- Parametrised, pipelined parity generator and checker for DATA_W-bit words with even/odd mode selection.
- Accepts words over a valid/ready handshake and registers the word, its generated parity bit and an optional check result into a one-deep output stage.
- Keeps a saturating error counter and a sticky error flag.
- Sits between a data source and a serialiser or link layer; also used on receive paths to validate an incoming parity bit.

Parameters:
- DATA_W, 8, data word width in bits (>=1).
- CNT_W, 8, width of the saturating parity-error counter (>=1).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  synchronous active-low reset.
- odd_mode  input  1  0 = even parity, 1 = odd parity; sampled on input acceptance.
- chk_en  input  1  1 = compare in_parity against the generated parity; sampled on acceptance.
- in_valid  input  1  input word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  input word.
- in_parity  input  1  received parity bit to check; ignored when chk_en=0.
- out_valid  output  1  output stage holds a word.
- out_ready  input  1  downstream accepts the output word.
- out_data  output  DATA_W  registered word.
- out_parity  output  1  generated parity for out_data.
- out_err  output  1  parity mismatch for out_data (0 when chk_en was 0).
- err_cnt  output  CNT_W  count of accepted words with out_err=1, saturating.
- sticky_err  output  1  set on any accepted mismatch, held until cleared.
- clr_err  input  1  synchronous clear of err_cnt and sticky_err.

Behaviour:
- Reset (rst_n=0 at a rising edge):
  - out_valid=0, out_data=0, out_parity=0, out_err=0, err_cnt=0, sticky_err=0.
  - in_ready is forced 0 while rst_n=0.
- Parity computation:
  - gen = XOR-reduction of all DATA_W bits of in_data, XOR odd_mode.
  - Even mode: data plus parity has an even number of ones. Odd mode: an odd number.
- Check: mismatch = chk_en & (in_parity != gen).
- Handshake:
  - in_ready = rst_n & (!out_valid | out_ready). This is combinational; it gives full throughput with no bubble.
  - Accept occurs when in_valid & in_ready.
  - Output transfer occurs when out_valid & out_ready.
- Output register updates on accept:
  - out_data <= in_data, out_parity <= gen, out_err <= mismatch, out_valid <= 1.
- Latency: exactly 1 cycle from accept to out_valid.
- Transfer without a new accept: out_valid <= 0. out_data, out_parity and out_err hold their last values.
- Simultaneous transfer and accept: the new word replaces the old one in the same edge and out_valid stays 1.
- Stall (out_valid=1, out_ready=0):
  - in_ready=0.
  - out_data, out_parity and out_err stay stable.
  - odd_mode, chk_en and in_data changes are ignored.
- in_valid with in_ready=0: no state change. The source must hold its word.
- Error counter and sticky flag:
  - On accept with mismatch=1: err_cnt increments, sticky_err <= 1.
  - err_cnt saturates at 2^CNT_W-1 and never wraps.
- clr_err=1: err_cnt <= 0, sticky_err <= 0. clr_err has priority over a same-cycle mismatch, so that error is discarded from the count and flag. out_err for that word is still reported.
- Reset mid-stall:
  - The pending output word is dropped (out_valid=0).
  - Counters clear.
  - in_ready returns to 1 on the first cycle after rst_n=1.
- Mode inputs are per-word; changing odd_mode between accepted words needs no flush.

Test Plan:
- Reset then idle -> all outputs 0, err_cnt=0. in_ready=1 on the cycle after rst_n rises while out_valid=0.
- DATA_W=8, even mode, chk_en=0, stream 8'hA5, 8'h01, 8'hFF with out_ready=1 -> out_parity 0, 1, 0 in consecutive cycles. Each word appears 1 cycle after accept. No bubbles. out_err=0.
- Odd mode, chk_en=1, in_data=8'h03 with in_parity=1 -> out_parity=1, out_err=0. Then in_data=8'h07 with in_parity=1 -> out_parity=0, out_err=1, err_cnt=1, sticky_err=1.
- out_ready=0 for 3 cycles with word 8'h3C held in the output stage -> in_ready=0. Output is stable, no counter change. When out_ready=1, the next word is accepted in the same cycle.
- CNT_W=2, 5 mismatching words -> err_cnt sequence 1, 2, 3, 3, 3. Then clr_err=1 together with a 6th mismatch -> err_cnt=0, sticky_err=0, out_err=1.
- rst_n low for 1 cycle while stalled with out_valid=1, err_cnt=2 -> out_valid=0, err_cnt=0, sticky_err=0. Normal acceptance resumes on the next cycle.
